// File: rtl/matmul_result_drain.sv
// Streams an N x N result matrix out of a synchronous-read memory in row-major
// order through a 2-entry skid FIFO, tagging each element with its row/column.
module matmul_result_drain #(
   parameter int MATRIX_DIM = 32,
   parameter int DATA_W     = 32,
   parameter int ADDR_W     = $clog2(MATRIX_DIM*MATRIX_DIM)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   output logic                          rd_en,
   output logic [ADDR_W-1:0]             rd_addr,
   input  logic [DATA_W-1:0]             rd_data,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [DATA_W-1:0]             out_data,
   output logic [$clog2(MATRIX_DIM)-1:0] out_row,
   output logic [$clog2(MATRIX_DIM)-1:0] out_col,
   output logic                          out_last,
   output logic                          busy,
   output logic                          done,
   output logic [DATA_W-1:0]             checksum
);

   localparam int IDX_W     = $clog2(MATRIX_DIM);
   localparam int LAST_ADDR = MATRIX_DIM*MATRIX_DIM - 1;

   typedef enum logic [1:0] {IDLE, DRAIN, FINISH} state_t;

   state_t state, state_next;

   logic [ADDR_W-1:0] addr;
   logic              issued_all;
   logic              in_flight;
   logic [IDX_W-1:0]  wr_row, wr_col;

   logic [DATA_W-1:0] fifo_data [2];
   logic [IDX_W-1:0]  fifo_row  [2];
   logic [IDX_W-1:0]  fifo_col  [2];
   logic [1:0]        fifo_last;
   logic              wr_ptr, rd_ptr;
   logic [1:0]        count;

   logic [DATA_W-1:0] sum;
   logic              push, pop, accept_start;
   logic [2:0]        level;

   assign accept_start = (state == IDLE) && start;
   assign out_valid    = (count != 2'd0);
   assign pop          = out_valid && out_ready;
   assign push         = in_flight;

   // Occupancy counts reads still in the memory pipeline so a late return always has a slot.
   assign level   = {1'b0, count} + {2'b0, in_flight};
   assign rd_en   = (state == DRAIN) && !issued_all && (level < (3'd2 + {2'b0, pop}));
   assign rd_addr = addr;

   assign out_data = fifo_data[rd_ptr];
   assign out_row  = fifo_row[rd_ptr];
   assign out_col  = fifo_col[rd_ptr];
   assign out_last = out_valid && fifo_last[rd_ptr];
   assign busy     = (state == DRAIN);
   assign done     = (state == FINISH);
   assign checksum = sum;

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = DRAIN;
         DRAIN:   if (pop && out_last) state_next = FINISH;
         FINISH:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= IDLE;
         addr       <= '0;
         issued_all <= 1'b0;
         in_flight  <= 1'b0;
         wr_row     <= '0;
         wr_col     <= '0;
         for (int i = 0; i < 2; i++) begin
            fifo_data[i] <= '0;
            fifo_row[i]  <= '0;
            fifo_col[i]  <= '0;
         end
         fifo_last  <= '0;
         wr_ptr     <= 1'b0;
         rd_ptr     <= 1'b0;
         count      <= '0;
         sum        <= '0;
      end else begin
         state     <= state_next;
         in_flight <= rd_en;

         // The address parks on the final location rather than wrapping past the matrix.
         if (accept_start) begin
            addr       <= '0;
            issued_all <= 1'b0;
            wr_row     <= '0;
            wr_col     <= '0;
            sum        <= '0;
         end else if (rd_en) begin
            if (addr == ADDR_W'(LAST_ADDR)) issued_all <= 1'b1;
            else                             addr       <= addr + ADDR_W'(1);
         end

         if (push) begin
            fifo_data[wr_ptr] <= rd_data;
            fifo_row[wr_ptr]  <= wr_row;
            fifo_col[wr_ptr]  <= wr_col;
            fifo_last[wr_ptr] <= (wr_row == IDX_W'(MATRIX_DIM-1)) &&
                                 (wr_col == IDX_W'(MATRIX_DIM-1));
            wr_ptr            <= ~wr_ptr;
            if (wr_col == IDX_W'(MATRIX_DIM-1)) begin
               wr_col <= '0;
               wr_row <= wr_row + IDX_W'(1);
            end else begin
               wr_col <= wr_col + IDX_W'(1);
            end
         end

         if (pop) begin
            rd_ptr <= ~rd_ptr;
            sum    <= sum + out_data;
         end

         count <= count + {1'b0, push} - {1'b0, pop};
      end
   end

endmodule

// File: tb/tb_matmul_result_drain.sv
// Directed bench: an N=2/8-bit instance covers ordering, backpressure, wrap,
// restart and reset abort; an N=4/32-bit instance covers random backpressure.
module tb_matmul_result_drain;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   cyc = 0;
   int   vectors = 0;
   int   miscompares = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   logic        start2 = 1'b0, out_ready2 = 1'b0;
   logic        rd_en2, out_valid2, out_last2, busy2, done2;
   logic [1:0]  rd_addr2;
   logic [7:0]  rd_data2 = '0, out_data2, checksum2;
   logic [0:0]  out_row2, out_col2;
   logic [7:0]  mem2 [4];

   matmul_result_drain #(.MATRIX_DIM(2), .DATA_W(8)) u2 (
      .clk(clk), .rst(rst), .start(start2), .rd_en(rd_en2), .rd_addr(rd_addr2),
      .rd_data(rd_data2), .out_valid(out_valid2), .out_ready(out_ready2),
      .out_data(out_data2), .out_row(out_row2), .out_col(out_col2),
      .out_last(out_last2), .busy(busy2), .done(done2), .checksum(checksum2)
   );

   logic        start4 = 1'b0, out_ready4 = 1'b0;
   logic        rd_en4, out_valid4, out_last4, busy4, done4;
   logic [3:0]  rd_addr4;
   logic [31:0] rd_data4 = '0, out_data4, checksum4;
   logic [1:0]  out_row4, out_col4;
   logic [31:0] mem4 [16];

   matmul_result_drain #(.MATRIX_DIM(4), .DATA_W(32)) u4 (
      .clk(clk), .rst(rst), .start(start4), .rd_en(rd_en4), .rd_addr(rd_addr4),
      .rd_data(rd_data4), .out_valid(out_valid4), .out_ready(out_ready4),
      .out_data(out_data4), .out_row(out_row4), .out_col(out_col4),
      .out_last(out_last4), .busy(busy4), .done(done4), .checksum(checksum4)
   );

   always @(posedge clk) if (rd_en2) rd_data2 <= mem2[rd_addr2];
   always @(posedge clk) if (rd_en4) rd_data4 <= mem4[rd_addr4];

   int q2_data[$], q2_row[$], q2_col[$], q2_last[$], q2_cyc[$];
   int rd_cnt2 = 0, done_cnt2 = 0, done_cyc2 = 0;
   int q4_data[$], q4_row[$], q4_col[$], q4_last[$];
   int rd_cnt4 = 0, done_cnt4 = 0, bad_addr4 = 0;

   // Handshakes are recorded mid-cycle; inputs only change just after rising edges.
   always @(negedge clk) begin
      if (rst) begin
         if (out_valid2 && out_ready2) begin
            q2_data.push_back(int'(out_data2));
            q2_row.push_back(int'(out_row2));
            q2_col.push_back(int'(out_col2));
            q2_last.push_back(int'(out_last2));
            q2_cyc.push_back(cyc);
         end
         if (rd_en2) rd_cnt2++;
         if (done2) begin
            done_cnt2++;
            done_cyc2 = cyc;
         end
         if (out_valid4 && out_ready4) begin
            q4_data.push_back(int'(out_data4));
            q4_row.push_back(int'(out_row4));
            q4_col.push_back(int'(out_col4));
            q4_last.push_back(int'(out_last4));
         end
         if (rd_en4) begin
            rd_cnt4++;
            if (rd_addr4 > 4'd15) bad_addr4++;
         end
         if (done4) done_cnt4++;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
      end
   endtask

   task automatic apply_stimulus();
      start2 = 1'b1;
      tick(1);
      start2 = 1'b0;
   endtask

   task automatic clear_log2();
      q2_data.delete(); q2_row.delete(); q2_col.delete(); q2_last.delete(); q2_cyc.delete();
      rd_cnt2 = 0;
      done_cnt2 = 0;
   endtask

   task automatic check_idle2(input string tag);
      check_output({tag, "_rd_en"},     32'(rd_en2),     0);
      check_output({tag, "_rd_addr"},   32'(rd_addr2),   0);
      check_output({tag, "_out_valid"}, 32'(out_valid2), 0);
      check_output({tag, "_out_last"},  32'(out_last2),  0);
      check_output({tag, "_busy"},      32'(busy2),      0);
      check_output({tag, "_done"},      32'(done2),      0);
      check_output({tag, "_out_row"},   32'(out_row2),   0);
      check_output({tag, "_out_col"},   32'(out_col2),   0);
      check_output({tag, "_out_data"},  32'(out_data2),  0);
      check_output({tag, "_checksum"},  32'(checksum2),  0);
   endtask

   task automatic check_seq2(input string tag, input int e0, input int e1, input int e2, input int e3);
      int exp_data[4];
      exp_data = '{e0, e1, e2, e3};
      check_output({tag, "_count"}, 32'(q2_data.size()), 4);
      check_output({tag, "_dones"}, 32'(done_cnt2), 1);
      if (q2_data.size() == 4) begin
         for (int i = 0; i < 4; i++) begin
            check_output($sformatf("%s_data%0d", tag, i), 32'(q2_data[i]), 32'(exp_data[i]));
            check_output($sformatf("%s_row%0d", tag, i),  32'(q2_row[i]),  32'(i / 2));
            check_output($sformatf("%s_col%0d", tag, i),  32'(q2_col[i]),  32'(i % 2));
            check_output($sformatf("%s_last%0d", tag, i), 32'(q2_last[i]), (i == 3) ? 32'd1 : 32'd0);
         end
      end
   endtask

   initial begin
      int ref_sum;
      $display("[TB] start");
      mem2 = '{8'd1, 8'd2, 8'd3, 8'd4};
      for (int i = 0; i < 16; i++) mem4[i] = 32'hF000_0000 + 32'(i) * 32'h0101_0101;

      tick(2);
      check_idle2("reset");
      rst = 1'b1;
      tick(1);

      // Free-flowing drain: latency, one element per cycle, done right after last.
      clear_log2();
      out_ready2 = 1'b1;
      apply_stimulus();
      check_output("lat_busy_t1", 32'(busy2), 1);
      check_output("lat_valid_t1", 32'(out_valid2), 0);
      tick(1);
      check_output("lat_valid_t2", 32'(out_valid2), 0);
      tick(1);
      check_output("lat_valid_t3", 32'(out_valid2), 1);
      check_output("lat_data_t3", 32'(out_data2), 1);
      tick(10);
      check_seq2("stream", 1, 2, 3, 4);
      if (q2_cyc.size() == 4) begin
         check_output("stream_b2b", 32'(q2_cyc[3] - q2_cyc[0]), 3);
         check_output("stream_done_gap", 32'(done_cyc2 - q2_cyc[3]), 1);
      end
      check_output("stream_checksum", 32'(checksum2), 10);
      check_output("stream_busy_end", 32'(busy2), 0);

      // Backpressure: reads stall at two, head element holds steady.
      clear_log2();
      out_ready2 = 1'b0;
      apply_stimulus();
      tick(4);
      check_output("bp_data_mid", 32'(out_data2), 1);
      tick(6);
      check_output("bp_reads_le2", 32'(rd_cnt2 <= 2), 1);
      check_output("bp_valid", 32'(out_valid2), 1);
      check_output("bp_data", 32'(out_data2), 1);
      check_output("bp_row_col", {30'd0, out_row2, out_col2}, 0);
      out_ready2 = 1'b1;
      tick(10);
      check_seq2("bp", 1, 2, 3, 4);
      check_output("bp_reads_total", 32'(rd_cnt2), 4);
      check_output("bp_checksum", 32'(checksum2), 10);

      // 8-bit checksum wrap: 360 mod 256.
      clear_log2();
      mem2 = '{8'd200, 8'd100, 8'd50, 8'd10};
      apply_stimulus();
      tick(10);
      check_seq2("wrap", 200, 100, 50, 10);
      check_output("wrap_checksum", 32'(checksum2), 104);

      // A second start mid-drain must be ignored.
      clear_log2();
      mem2 = '{8'd1, 8'd2, 8'd3, 8'd4};
      apply_stimulus();
      tick(1);
      apply_stimulus();
      tick(12);
      check_seq2("restart_ign", 1, 2, 3, 4);
      check_output("restart_ign_valid", 32'(out_valid2), 0);
      check_output("restart_ign_checksum", 32'(checksum2), 10);

      // Reset after the second handshake aborts cleanly; a new run starts from (0,0).
      clear_log2();
      apply_stimulus();
      for (int n = 0; n < 20 && q2_data.size() < 2; n++) tick(1);
      check_output("abort_hs_seen", 32'(q2_data.size()), 2);
      rst = 1'b0;
      tick(1);
      check_idle2("abort");
      rst = 1'b1;
      tick(4);
      check_output("abort_quiet_valid", 32'(out_valid2), 0);
      check_output("abort_quiet_count", 32'(q2_data.size()), 2);
      clear_log2();
      apply_stimulus();
      tick(12);
      check_seq2("after_abort", 1, 2, 3, 4);
      check_output("after_abort_checksum", 32'(checksum2), 10);

      // N=4 with random 50% ready.
      start4 = 1'b1;
      tick(1);
      start4 = 1'b0;
      for (int n = 0; n < 120; n++) begin
         out_ready4 = 1'($urandom_range(0, 1));
         tick(1);
      end
      out_ready4 = 1'b1;
      tick(6);
      ref_sum = 0;
      for (int i = 0; i < 16; i++) ref_sum += int'(mem4[i]);
      check_output("n4_count", 32'(q4_data.size()), 16);
      check_output("n4_reads", 32'(rd_cnt4), 16);
      check_output("n4_bad_addr", 32'(bad_addr4), 0);
      check_output("n4_dones", 32'(done_cnt4), 1);
      check_output("n4_checksum", checksum4, 32'(ref_sum));
      if (q4_data.size() == 16) begin
         int lasts;
         lasts = 0;
         for (int i = 0; i < 16; i++) begin
            check_output($sformatf("n4_data%0d", i), 32'(q4_data[i]), mem4[i]);
            check_output($sformatf("n4_row%0d", i),  32'(q4_row[i]),  32'(i / 4));
            check_output($sformatf("n4_col%0d", i),  32'(q4_col[i]),  32'(i % 4));
            lasts += q4_last[i];
         end
         check_output("n4_last_count", 32'(lasts), 1);
         check_output("n4_last_pos", 32'(q4_last[15]), 1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
